// File: rtl/rv_iommu_pkg.sv
// Shared IOMMU package: regbus cut FSM states, default watchdog depth and the
// default regbus request/response shapes used when no struct types are supplied.
package rv_iommu_pkg;

  localparam int unsigned DEFAULT_REGBUS_TIMEOUT = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } rv_iommu_regbus_cut_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } regbus_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } regbus_rsp_t;

endpackage

// File: rtl/rv_iommu_regbus_cut.sv
// Register-bus timing cut with an optional stall watchdog.
// Every request is captured before it reaches the register map, and every
// response is captured before it goes back to the bridge. Nothing passes
// combinationally from one port to the other.
// Optional feature macro: RV_IOMMU_REGBUS_TIMEOUT_EN. When it is defined, an
// access that stalls TIMEOUT_CYCLES cycles in the register map is aborted. It
// is then answered with error=1 and rdata=0.
module rv_iommu_regbus_cut
  import rv_iommu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_REGBUS_TIMEOUT,
  parameter type         reg_req_t      = regbus_req_t,
  parameter type         reg_rsp_t      = regbus_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  reg_req_t slv_req_i,
  output reg_rsp_t slv_rsp_o,
  output reg_req_t mst_req_o,
  input  reg_rsp_t mst_rsp_i,
  output logic     timeout_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("rv_iommu_regbus_cut: TIMEOUT_CYCLES must be at least 2");
  end

  rv_iommu_regbus_cut_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic                  req_write_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;
  logic [STRB_WIDTH-1:0] req_wstrb_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_error_q;
  logic                  timeout_hit;

`ifdef RV_IOMMU_REGBUS_TIMEOUT_EN
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt_q;

  // Stall counter: zero while idle, counts ISSUE cycles and holds at the last value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (state_q == ISSUE && cnt_q != CNT_LAST) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A ready from the map in the final cycle takes priority over the abort
  assign timeout_hit = (state_q == ISSUE) && !mst_rsp_i.ready && (cnt_q == CNT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  assign timeout_o = timeout_hit;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; IDLE always lasts one cycle so a completed request is never resampled
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (slv_req_i.valid) state_d = ISSUE;
      ISSUE:   if (mst_rsp_i.ready || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the request on acceptance and the response (real or aborted) on completion
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_addr_q  <= '0;
      req_write_q <= 1'b0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      if (state_q == IDLE && slv_req_i.valid) begin
        req_addr_q  <= slv_req_i.addr;
        req_write_q <= slv_req_i.write;
        req_wdata_q <= slv_req_i.wdata;
        req_wstrb_q <= slv_req_i.wstrb;
      end
      if (state_q == ISSUE) begin
        if (mst_rsp_i.ready) begin
          rsp_rdata_q <= mst_rsp_i.rdata;
          rsp_error_q <= mst_rsp_i.error;
        end else if (timeout_hit) begin
          rsp_rdata_q <= '0;
          rsp_error_q <= 1'b1;
        end
      end
    end
  end

  // Port outputs come straight from registers and are zeroed outside their own state
  always_comb begin
    mst_req_o = '0;
    slv_rsp_o = '0;
    if (state_q == ISSUE) begin
      mst_req_o.addr  = req_addr_q;
      mst_req_o.write = req_write_q;
      mst_req_o.wdata = req_wdata_q;
      mst_req_o.wstrb = req_wstrb_q;
      mst_req_o.valid = 1'b1;
    end
    if (state_q == RESP) begin
      slv_rsp_o.rdata = rsp_rdata_q;
      slv_rsp_o.error = rsp_error_q;
      slv_rsp_o.ready = 1'b1;
    end
  end

endmodule
